// File: rtl/stream_packet_arbiter.sv
// -----------------------------------------------------------------------------
// stream_packet_arbiter
//
// Packet-level round-robin arbiter that lets N narrow input streams share one
// stream_upsize instance. A source is granted on its first beat and keeps the
// grant until its last beat is accepted, so packets never interleave at the
// upsizer input. The granted source index is exported on m_id_o so downstream
// logic can tag the widened output.
//
// Parameters:
//   T_DATA_WIDTH  width of one narrow beat
//   N_SOURCES     number of requesting streams (>= 2)
//   ID_WIDTH      $clog2(N_SOURCES), width of m_id_o (not overridable)
//
// Ports:
//   clk_i      in   clock
//   rst_i      in   asynchronous reset, active-high
//   s_data_i   in   per-source beat data (unpacked array, N_SOURCES entries)
//   s_last_i   in   per-source last-beat flag
//   s_valid_i  in   per-source valid
//   s_ready_o  out  per-source ready (only the granted source can see 1)
//   m_data_o   out  granted beat data
//   m_last_o   out  granted last flag
//   m_valid_o  out  granted valid
//   m_ready_i  in   downstream (upsizer) ready
//   m_id_o     out  index of the granted source, stable for the whole packet
//   m_beat_o   out  16-bit zero-based beat index in the current packet
//                   (present only when STREAM_ARB_BEAT_CNT_EN is defined)
//
// Optional feature macro: STREAM_ARB_BEAT_CNT_EN
// -----------------------------------------------------------------------------
module stream_packet_arbiter #(
  parameter  int T_DATA_WIDTH = 1,
  parameter  int N_SOURCES    = 4,
  localparam int ID_WIDTH     = $clog2(N_SOURCES)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [N_SOURCES],
  input  logic [N_SOURCES-1:0]    s_last_i,
  input  logic [N_SOURCES-1:0]    s_valid_i,
  output logic [N_SOURCES-1:0]    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [ID_WIDTH-1:0]     m_id_o
`ifdef STREAM_ARB_BEAT_CNT_EN
  ,
  output logic [15:0]             m_beat_o
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ID_WIDTH-1:0] grant_r;
  logic [ID_WIDTH-1:0] rr_ptr_r;
  logic [ID_WIDTH-1:0] pick_s;
  logic                found_s;
  logic                beat_hs_s;
  logic                pkt_end_s;
  logic [ID_WIDTH-1:0] ptr_nxt_s;

  // Round-robin search: first valid source starting at rr_ptr, wrapping modulo N.
  always_comb begin
    pick_s  = rr_ptr_r;
    found_s = 1'b0;
    for (int k = 0; k < N_SOURCES; k++) begin
      int sum;
      logic [ID_WIDTH-1:0] idx;
      sum = int'(rr_ptr_r) + k;
      if (sum >= N_SOURCES) begin
        sum = sum - N_SOURCES;
      end else begin
        sum = sum;
      end
      idx = ID_WIDTH'(sum);
      if (!found_s && s_valid_i[idx]) begin
        pick_s  = idx;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next round-robin pointer after the granted packet ends: grant+1 with wrap.
  always_comb begin
    if (grant_r == ID_WIDTH'(N_SOURCES - 1)) begin
      ptr_nxt_s = {ID_WIDTH{1'b0}};
    end else begin
      ptr_nxt_s = grant_r + ID_WIDTH'(1);
    end
  end

  // Next-state logic and the combinational grant mux (no added per-beat latency).
  always_comb begin
    state_nxt_s = state_r;
    m_data_o    = s_data_i[0];
    m_last_o    = 1'b0;
    m_valid_o   = 1'b0;
    s_ready_o   = {N_SOURCES{1'b0}};
    m_id_o      = {ID_WIDTH{1'b0}};
    beat_hs_s   = 1'b0;
    pkt_end_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        m_data_o           = s_data_i[grant_r];
        m_last_o           = s_last_i[grant_r];
        m_valid_o          = s_valid_i[grant_r];
        s_ready_o[grant_r] = m_ready_i;
        m_id_o             = grant_r;
        beat_hs_s          = s_valid_i[grant_r] & m_ready_i;
        pkt_end_s          = beat_hs_s & s_last_i[grant_r];
        if (pkt_end_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= IDLE;
      grant_r  <= {ID_WIDTH{1'b0}};
      rr_ptr_r <= {ID_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE) && found_s) begin
        grant_r <= pick_s;
      end else begin
        grant_r <= grant_r;
      end
      if (pkt_end_s) begin
        rr_ptr_r <= ptr_nxt_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

`ifdef STREAM_ARB_BEAT_CNT_EN
  logic [15:0] beat_cnt_r;

  // Beat index within the packet: counts accepted beats, clears on the last one,
  // and sticks at all-ones on very long packets rather than wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt_r <= 16'h0000;
    end else if (pkt_end_s) begin
      beat_cnt_r <= 16'h0000;
    end else if (beat_hs_s && (beat_cnt_r != 16'hFFFF)) begin
      beat_cnt_r <= beat_cnt_r + 16'h0001;
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  assign m_beat_o = beat_cnt_r;
`endif

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for stream_packet_arbiter (N_SOURCES=4, T_DATA_WIDTH=8).
// Each source owns a queue of whole packets. A transaction-level model grants
// whole packets in round-robin order and pushes every beat of the granted
// packet into a scoreboard; an independent monitor pops it on each accepted
// output beat and compares data, last, id (and beat index when enabled).
// -----------------------------------------------------------------------------
module tb_stream_packet_arbiter;

  localparam int NS = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [DW-1:0] s_data_i [NS];
  logic [NS-1:0] s_last_i;
  logic [NS-1:0] s_valid_i;
  logic [NS-1:0] s_ready_o;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [1:0]    m_id_o;
`ifdef STREAM_ARB_BEAT_CNT_EN
  logic [15:0]   m_beat_o;
`endif

  stream_packet_arbiter #(
    .T_DATA_WIDTH(DW),
    .N_SOURCES   (NS)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .s_data_i (s_data_i),
    .s_last_i (s_last_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .m_data_o (m_data_o),
    .m_last_o (m_last_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i),
    .m_id_o   (m_id_o)
`ifdef STREAM_ARB_BEAT_CNT_EN
    ,
    .m_beat_o (m_beat_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic [1:0]    id;
  } exp_t;

  exp_t          exp_q [$];
  logic [DW-1:0] src_d [NS][$];
  bit            src_l [NS][$];

  int   checks = 0;
  int   errors = 0;
  bit   mbusy  = 1'b0;
  int   mg     = 0;
  int   mptr   = 0;
  int   mcnt   = 0;
  bit   gen_en = 1'b1;
  bit   always_v = 1'b0;
  bit   rdy_full = 1'b0;
  int   mon_beat = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source drivers: present the head beat of each source queue, random valid gaps.
  task automatic drive();
    for (int s = 0; s < NS; s++) begin
      if (gen_en && (src_d[s].size() == 0) && ($urandom_range(0, 2) == 0)) begin
        int len;
        len = $urandom_range(1, 5);
        for (int b = 0; b < len; b++) begin
          src_d[s].push_back(DW'($urandom));
          src_l[s].push_back(b == len - 1);
        end
      end
      if (src_d[s].size() > 0) begin
        s_data_i[s]  = src_d[s][0];
        s_last_i[s]  = src_l[s][0];
        s_valid_i[s] = always_v || ($urandom_range(0, 3) != 0);
      end else begin
        s_data_i[s]  = '0;
        s_last_i[s]  = 1'b0;
        s_valid_i[s] = 1'b0;
      end
    end
    m_ready_i = rdy_full ? 1'b1 : ($urandom_range(0, 3) != 0);
  endtask

  // One cycle: evaluate the reference model at negedge, then advance stimulus.
  task automatic step();
    logic [NS-1:0] exp_rdy;
    logic [NS-1:0] hs;
    @(negedge clk);
    exp_rdy = '0;
    if (mbusy) exp_rdy[mg] = m_ready_i;
    check_eq("m_valid", {31'd0, m_valid_o}, {31'd0, mbusy && s_valid_i[mg]});
    check_eq("s_ready", {28'd0, s_ready_o}, {28'd0, exp_rdy});
    if (mbusy) check_eq("m_id_busy", {30'd0, m_id_o}, mg);
    hs = s_valid_i & exp_rdy;
    if (mbusy) begin
      if (hs[mg]) begin
        if (s_last_i[mg]) begin
          mbusy = 1'b0;
          mptr  = (mg + 1) % NS;
          mcnt  = 0;
        end else begin
          mcnt++;
        end
      end
    end else begin
      for (int k = 0; k < NS; k++) begin
        int idx;
        idx = (mptr + k) % NS;
        if (!mbusy && s_valid_i[idx]) begin
          mbusy = 1'b1;
          mg    = idx;
          for (int i = 0; i < src_d[idx].size(); i++) begin
            exp_t e;
            e.d  = src_d[idx][i];
            e.l  = src_l[idx][i];
            e.id = idx[1:0];
            exp_q.push_back(e);
            if (src_l[idx][i]) break;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++) begin
      if (hs[s]) begin
        void'(src_d[s].pop_front());
        void'(src_l[s].pop_front());
      end
    end
    drive();
  endtask

  // Scoreboard monitor: compares every presented beat, pops on acceptance.
  always @(negedge clk) begin
    if (rst_i) begin
      mon_beat = 0;
    end else if (m_valid_o) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_beat", {31'd0, m_valid_o}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q[0];
        check_eq("m_data", {24'd0, m_data_o}, {24'd0, e.d});
        check_eq("m_last", {31'd0, m_last_o}, {31'd0, e.l});
        check_eq("m_id",   {30'd0, m_id_o},   {30'd0, e.id});
`ifdef STREAM_ARB_BEAT_CNT_EN
        check_eq("m_beat", {16'd0, m_beat_o}, mon_beat);
`endif
        if (m_ready_i) begin
          void'(exp_q.pop_front());
          mon_beat = e.l ? 0 : mon_beat + 1;
        end
      end
    end
  end

  initial begin
    int guard;
    rst_i     = 1'b1;
    s_valid_i = '0;
    s_last_i  = '0;
    m_ready_i = 1'b0;
    for (int s = 0; s < NS; s++) s_data_i[s] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_m_valid", {31'd0, m_valid_o}, 32'd0);
    check_eq("rst_s_ready", {28'd0, s_ready_o}, 32'd0);
    check_eq("rst_m_id",    {30'd0, m_id_o},    32'd0);
    check_eq("rst_m_last",  {31'd0, m_last_o},  32'd0);
`ifdef STREAM_ARB_BEAT_CNT_EN
    check_eq("rst_m_beat",  {16'd0, m_beat_o},  32'd0);
`endif
    rst_i = 1'b0;
    drive();

    // Random valid gaps and back-pressure.
    repeat (600) step();

    // Every source continuously valid, no back-pressure: strict rotation.
    always_v = 1'b1;
    rdy_full = 1'b1;
    repeat (300) step();
    always_v = 1'b0;
    rdy_full = 1'b0;

    // Reset in the middle of a multi-beat packet.
    guard = 0;
    while (!(mbusy && (mcnt >= 1) && (src_d[mg].size() > 1)) && (guard < 2000)) begin
      step();
      guard++;
    end
    check_eq("midpkt_reached", guard < 2000, 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("midrst_m_valid", {31'd0, m_valid_o}, 32'd0);
    check_eq("midrst_s_ready", {28'd0, s_ready_o}, 32'd0);
    check_eq("midrst_m_id",    {30'd0, m_id_o},    32'd0);
`ifdef STREAM_ARB_BEAT_CNT_EN
    check_eq("midrst_m_beat",  {16'd0, m_beat_o},  32'd0);
`endif
    exp_q.delete();
    for (int s = 0; s < NS; s++) begin
      src_d[s].delete();
      src_l[s].delete();
    end
    mbusy = 1'b0;
    mptr  = 0;
    mcnt  = 0;
    s_valid_i = '0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    drive();

    // More random traffic after reset: round robin restarts at source 0.
    repeat (300) step();

    // Drain everything still queued.
    gen_en   = 1'b0;
    rdy_full = 1'b1;
    guard    = 0;
    while ((mbusy || (exp_q.size() != 0) || (src_d[0].size() != 0) || (src_d[1].size() != 0) ||
            (src_d[2].size() != 0) || (src_d[3].size() != 0)) && (guard < 3000)) begin
      step();
      guard++;
    end
    check_eq("drain_done", guard < 3000, 32'd1);
    check_eq("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
